// File: rtl/boruss_mem_bus_controller.sv
// boruss_mem_bus_controller: address-decoded ROM / on-chip RAM / unmapped
// data port with req/ack handshake, RAM wait states and bus-error reporting.
// The instruction port is a combinational pass-through to external ROM port A.
// Optional macro BORUSS_MEM_PERF_CNT_EN adds saturating read/write/error counters.
module boruss_mem_bus_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ROM_SIZE   = 128,
  parameter int RAM_BASE   = 128,
  parameter int RAM_DEPTH  = 128,
  parameter int RAM_WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] rom_i_addr,
  input  logic [DATA_WIDTH-1:0] rom_i_data,
  output logic [ADDR_WIDTH-1:0] rom_d_addr,
  input  logic [DATA_WIDTH-1:0] rom_d_data,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_err,
  output logic                  busy
`ifdef BORUSS_MEM_PERF_CNT_EN
  ,
  output logic [15:0]           perf_rd_cnt,
  output logic [15:0]           perf_wr_cnt,
  output logic [15:0]           perf_err_cnt
`endif
);

  localparam int RAM_IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] ROM_END = (ADDR_WIDTH+1)'(ROM_SIZE);
  localparam logic [ADDR_WIDTH:0] RAM_LO  = (ADDR_WIDTH+1)'(RAM_BASE);
  localparam logic [ADDR_WIDTH:0] RAM_HI  = (ADDR_WIDTH+1)'(RAM_BASE + RAM_DEPTH);
  localparam bit                  HAS_WAIT  = (RAM_WAIT > 0);
  localparam logic [3:0]          WAIT_INIT = 4'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [3:0]              wait_cnt;

  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [ADDR_WIDTH:0]     ext_addr;
  logic                    is_rom;
  logic                    is_ram;
  logic [RAM_IW-1:0]       ram_idx;
  logic                    accept;
  logic                    go_wait;
  logic                    enter_resp;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   resp_rdata;

  logic [DATA_WIDTH-1:0]   ram [RAM_DEPTH];

  assign rom_i_addr = instr_addr;
  assign instr_data = rom_i_data;
  assign busy       = (state != S_IDLE);

  // Transaction under decode: live inputs while IDLE (accept edge), latched copy afterwards.
  // This lets a zero-wait response complete on the accept edge itself.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == S_IDLE) begin
      cur_we    = data_we;
      cur_addr  = data_addr;
      cur_wdata = data_wdata;
    end
  end

  assign rom_d_addr = cur_addr;
  assign ext_addr   = {1'b0, cur_addr};
  assign is_rom     = (ext_addr < ROM_END);
  assign is_ram     = !is_rom && (ext_addr >= RAM_LO) && (ext_addr < RAM_HI);
  assign ram_idx    = RAM_IW'(ext_addr - RAM_LO);

  assign accept     = (state == S_IDLE) && data_req;
  assign go_wait    = accept && is_ram && HAS_WAIT;
  assign enter_resp = (accept && !go_wait) || ((state == S_WAIT) && (wait_cnt == 4'd0));
  assign resp_err   = !(is_ram || (is_rom && !cur_we));

  // Response data: zero for writes and errors, else RAM array or ROM port B.
  always_comb begin
    resp_rdata = '0;
    if (!cur_we && !resp_err) begin
      resp_rdata = is_ram ? ram[ram_idx] : rom_d_data;
    end
  end

  // RAM array write on the edge entering RESP; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && is_ram && cur_we) begin
      ram[ram_idx] <= cur_wdata;
    end
  end

  // Data-port FSM with registered ack/err/rdata.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
      data_ack   <= 1'b0;
      data_err   <= 1'b0;
      data_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          data_ack <= 1'b0;
          data_err <= 1'b0;
          if (accept) begin
            lat_we    <= data_we;
            lat_addr  <= data_addr;
            lat_wdata <= data_wdata;
            if (go_wait) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          data_ack <= 1'b0;
          data_err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        state      <= S_RESP;
        data_ack   <= 1'b1;
        data_err   <= resp_err;
        data_rdata <= resp_rdata;
      end
    end
  end

`ifdef BORUSS_MEM_PERF_CNT_EN
  // Saturating counters, one event per ack, classified by the acked transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else if (data_ack) begin
      if (data_err) begin
        if (perf_err_cnt != 16'hFFFF) perf_err_cnt <= perf_err_cnt + 16'd1;
      end else if (lat_we) begin
        if (perf_wr_cnt != 16'hFFFF) perf_wr_cnt <= perf_wr_cnt + 16'd1;
      end else begin
        if (perf_rd_cnt != 16'hFFFF) perf_rd_cnt <= perf_rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_boruss_mem_bus_controller.sv
// Self-checking bench for boruss_mem_bus_controller: directed cases plus
// random transactions against a behavioural memory-map model.
module tb_boruss_mem_bus_controller;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int ROM_SIZE  = 128;
  localparam int RAM_BASE  = 128;
  localparam int RAM_DEPTH = 64;
  localparam int RAM_WAIT  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] rom_i_addr;
  logic [DW-1:0] rom_i_data;
  logic [AW-1:0] rom_d_addr;
  logic [DW-1:0] rom_d_data;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ack;
  logic [DW-1:0] data_rdata;
  logic          data_err;
  logic          busy;
`ifdef BORUSS_MEM_PERF_CNT_EN
  logic [15:0]   perf_rd_cnt;
  logic [15:0]   perf_wr_cnt;
  logic [15:0]   perf_err_cnt;
`endif

  logic [DW-1:0] rom_mem   [256];
  logic [DW-1:0] ram_model [RAM_DEPTH];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          exp_rd   = 0;
  int          exp_wr   = 0;
  int          exp_err  = 0;
  int unsigned cycle    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  assign rom_i_data = rom_mem[rom_i_addr];
  assign rom_d_data = rom_mem[rom_d_addr];

  boruss_mem_bus_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ROM_SIZE  (ROM_SIZE),
    .RAM_BASE  (RAM_BASE),
    .RAM_DEPTH (RAM_DEPTH),
    .RAM_WAIT  (RAM_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .rom_i_addr(rom_i_addr),
    .rom_i_data(rom_i_data),
    .rom_d_addr(rom_d_addr),
    .rom_d_data(rom_d_data),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_ack  (data_ack),
    .data_rdata(data_rdata),
    .data_err  (data_err),
    .busy      (busy)
`ifdef BORUSS_MEM_PERF_CNT_EN
    ,
    .perf_rd_cnt (perf_rd_cnt),
    .perf_wr_cnt (perf_wr_cnt),
    .perf_err_cnt(perf_err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = ROM, 1 = RAM, 2 = unmapped
  function automatic int region(input logic [AW-1:0] a);
    int v;
    v = int'(a);
    if (v < ROM_SIZE) return 0;
    if (v >= RAM_BASE && v < RAM_BASE + RAM_DEPTH) return 1;
    return 2;
  endfunction

`ifdef BORUSS_MEM_PERF_CNT_EN
  task automatic check_perf(input string tag);
    check({tag, "_perf_rd"},  32'(perf_rd_cnt),  32'(exp_rd));
    check({tag, "_perf_wr"},  32'(perf_wr_cnt),  32'(exp_wr));
    check({tag, "_perf_err"}, 32'(perf_err_cnt), 32'(exp_err));
  endtask
`endif

  // Called just after a posedge with the controller idle; returns just after
  // the cycle following the ack.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int            rk;
    int            lat;
    int            cyc;
    logic          e_err;
    logic [DW-1:0] e_rd;
    rk    = region(addr);
    e_err = (rk == 2) || (rk == 0 && we);
    if (we || e_err)  e_rd = '0;
    else if (rk == 1) e_rd = ram_model[int'(addr) - RAM_BASE];
    else              e_rd = rom_mem[addr];
    lat = (rk == 1) ? 1 + RAM_WAIT : 1;

    instr_addr = AW'($urandom);
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = addr;
    data_wdata = wd;
    #1;
    check("instr_data", 32'(instr_data), 32'(rom_mem[instr_addr]));

    @(posedge clk); #1;
    data_req   = 1'b0;
    data_we    = 1'($urandom);
    data_addr  = AW'($urandom);
    data_wdata = DW'($urandom);
    cyc = 1;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (data_ack !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ack_latency", 32'(cyc), 32'(lat));
    check("ack", 32'(data_ack), 32'd1);
    check("rdata", 32'(data_rdata), 32'(e_rd));
    check("err", 32'(data_err), 32'(e_err));

    if (rk == 1 && we) ram_model[int'(addr) - RAM_BASE] = wd;
    if (e_err)   exp_err++;
    else if (we) exp_wr++;
    else         exp_rd++;

    @(posedge clk); #1;
    check("ack_one_cycle", 32'(data_ack), 32'd0);
    check("idle_after_ack", 32'(busy), 32'd0);
    check("rdata_hold", 32'(data_rdata), 32'(e_rd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int            acks;
    int            k;
    int unsigned   ack_cyc [3];
    logic [AW-1:0] b2b_addr [3];

    for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
    reset      = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    instr_addr = '0;

    // Reset hold
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack",   32'(data_ack),   32'd0);
    check("reset_err",   32'(data_err),   32'd0);
    check("reset_rdata", 32'(data_rdata), 32'd0);
    check("reset_busy",  32'(busy),       32'd0);
`ifdef BORUSS_MEM_PERF_CNT_EN
    check_perf("reset");
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // ROM read with concurrent instruction fetch
    rom_mem[8'h10] = 8'hA5;
    rom_mem[8'h03] = 8'h3C;
    instr_addr = 8'h03;
    #1;
    check("instr_direct", 32'(instr_data), 32'h3C);
    check("rom_i_addr", 32'(rom_i_addr), 32'h03);
    txn(1'b0, 8'h10, '0);

    // Fill RAM so every later read has a defined expected value
    for (int i = 0; i < RAM_DEPTH; i++) txn(1'b1, AW'(RAM_BASE + i), DW'($urandom));

    // RAM write/read and region boundaries
    txn(1'b1, 8'h80, 8'h5A);
    txn(1'b0, 8'h80, '0);
    txn(1'b1, 8'h05, 8'h77);
    txn(1'b0, 8'hF0, '0);
    txn(1'b0, 8'h7F, '0);
    txn(1'b0, 8'hBF, '0);
    txn(1'b0, 8'hC0, '0);
    txn(1'b1, 8'hFF, 8'h99);
    txn(1'b0, 8'h00, '0);
`ifdef BORUSS_MEM_PERF_CNT_EN
    check_perf("directed");
`endif

    // Reset during the second wait cycle aborts the write
    txn(1'b1, 8'h81, 8'h22);
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 8'h81;
    data_wdata = 8'h11;
    @(posedge clk); #1;
    data_req = 1'b0;
    check("abort_busy_wait", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_ack",   32'(data_ack),   32'd0);
    check("abort_rdata", 32'(data_rdata), 32'd0);
    check("abort_err",   32'(data_err),   32'd0);
    reset = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (data_ack === 1'b1) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    txn(1'b0, 8'h81, '0);
`ifdef BORUSS_MEM_PERF_CNT_EN
    check_perf("abort");
`endif

    // Random traffic over the whole address space
    for (int i = 0; i < 60; i++) txn(1'($urandom), AW'($urandom), DW'($urandom));
`ifdef BORUSS_MEM_PERF_CNT_EN
    check_perf("random");
`endif

    // Back-to-back RAM reads with data_req held high
    b2b_addr[0] = 8'h90;
    b2b_addr[1] = 8'hA0;
    b2b_addr[2] = 8'hBF;
    k = 0;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = b2b_addr[0];
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(posedge clk); #1;
      if (data_ack === 1'b1) begin
        ack_cyc[k] = cycle;
        check("b2b_rdata", 32'(data_rdata), 32'(ram_model[int'(b2b_addr[k]) - RAM_BASE]));
        check("b2b_err", 32'(data_err), 32'd0);
        exp_rd++;
        k++;
        if (k < 3) data_addr = b2b_addr[k];
        else       data_req  = 1'b0;
      end
    end
    data_req = 1'b0;
    check("b2b_ack_count", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b_gap0", ack_cyc[1] - ack_cyc[0], 32'(RAM_WAIT + 2));
      check("b2b_gap1", ack_cyc[2] - ack_cyc[1], 32'(RAM_WAIT + 2));
    end
    @(posedge clk); #1;
    check("b2b_idle", 32'(busy), 32'd0);
`ifdef BORUSS_MEM_PERF_CNT_EN
    check_perf("b2b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/boruss_mem_bus_controller.md
Name: boruss_mem_bus_controller

Overview:
Parametrised next-generation memory controller for the Boruss CPU. It replaces the external ROM/RAM select line with an address-decoded map: ROM region, on-chip RAM region, and unmapped space. The instruction port stays a combinational ROM read. The data port uses a req/ack handshake with programmable RAM wait states, registered read data and bus-error reporting. It sits between the CPU core and an external dual-read-port ROM; the RAM array is held inside the block.

Parameters:
ADDR_WIDTH, 8, address bus width.
DATA_WIDTH, 8, data bus width.
ROM_SIZE, 128, ROM region is [0, ROM_SIZE).
RAM_BASE, 128, first RAM address.
RAM_DEPTH, 128, RAM words; RAM region is [RAM_BASE, RAM_BASE+RAM_DEPTH).
RAM_WAIT, 1, extra wait cycles per RAM access (0..15).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
instr_addr  in  ADDR_WIDTH  instruction fetch address
instr_data  out  DATA_WIDTH  fetched instruction, combinational
rom_i_addr  out  ADDR_WIDTH  external ROM port A address (= instr_addr)
rom_i_data  in  DATA_WIDTH  external ROM port A data
rom_d_addr  out  ADDR_WIDTH  external ROM port B address (latched data address)
rom_d_data  in  DATA_WIDTH  external ROM port B data
data_req  in  1  data transaction request
data_we  in  1  1 = write, 0 = read; sampled at accept
data_addr  in  ADDR_WIDTH  data address; sampled at accept
data_wdata  in  DATA_WIDTH  write data; sampled at accept
data_ack  out  1  one-cycle completion pulse
data_rdata  out  DATA_WIDTH  registered read data, valid while data_ack=1
data_err  out  1  error flag, valid while data_ack=1
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Instruction path: rom_i_addr = instr_addr; instr_data = rom_i_data. It has no latency and is independent of the data FSM.
- Address decode (on the latched address):
  - ROM if addr < ROM_SIZE.
  - RAM if RAM_BASE <= addr < RAM_BASE+RAM_DEPTH.
  - Otherwise UNMAPPED.
  - RAM index = addr - RAM_BASE.
  - Compare in ADDR_WIDTH+1 bits so the end bound does not wrap.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if data_req=1, latch we/addr/wdata.
    - RAM target with RAM_WAIT>0: go to WAIT, load wait counter with RAM_WAIT-1.
    - Any other target: go to RESP.
  - WAIT: decrement the counter. At 0, go to RESP.
  - RESP: data_ack=1 for exactly one cycle, then go to IDLE.
- Latency (accept edge = cycle N): ack in cycle N+1 for ROM, UNMAPPED, or RAM with RAM_WAIT=0; ack in cycle N+1+RAM_WAIT for RAM.
- RAM write: the array is written on the edge that enters RESP. RAM read: data_rdata is loaded from the array on the edge entering RESP.
- ROM read: rom_d_addr is driven from the latched address. data_rdata is loaded from rom_d_data on the edge entering RESP.
- ROM write: no effect; data_err=1, data_rdata=0.
- UNMAPPED read or write: data_err=1, data_rdata=0, RAM untouched.
- data_rdata holds its value after the ack until the next response. For writes, data_rdata=0.
- Inputs are ignored while busy=1. If data_req is still 1 during the RESP cycle, it is taken as a new request in the following IDLE cycle, giving one idle cycle between back-to-back transactions.
- Reset (reset=0 at a clock edge, in any state including mid-WAIT): state goes to IDLE. The in-flight transaction is aborted with no ack and no RAM write. Outputs data_ack=0, data_err=0, data_rdata=0, busy=0. RAM contents are not cleared.

Optional Feature:
BORUSS_MEM_PERF_CNT_EN
- Defined:
  - Adds outputs perf_rd_cnt [15:0], perf_wr_cnt [15:0] and perf_err_cnt [15:0].
  - perf_rd_cnt / perf_wr_cnt increment on each error-free read/write ack; perf_err_cnt on each ack with data_err=1.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then idle: hold reset=0 for 2 cycles -> data_ack=0, data_err=0, data_rdata=0, busy=0.
- ROM read: rom_d_data=8'hA5, req read addr 8'h10 at cycle N -> ack at N+1, rdata=8'hA5, err=0; simultaneously instr_addr=8'h03 with rom_i_data=8'h3C -> instr_data=8'h3C at once.
- RAM write then read (RAM_WAIT=1): write 8'h5A to 8'h80 -> ack at N+2, err=0; read 8'h80 -> ack 2 cycles after accept, rdata=8'h5A.
- Error cases: write 8'h77 to ROM addr 8'h05 -> ack at N+1 with err=1, rdata=0. With RAM_BASE=128, RAM_DEPTH=64, read 8'hF0 -> err=1, rdata=0.
- Reset mid-WAIT (RAM_WAIT=3): start write 8'h11 to 8'h81, assert reset=0 in the 2nd wait cycle -> no ack, busy=0; a later read of 8'h81 returns the prior contents, not 8'h11.
- Back-to-back with the macro defined: hold data_req=1 for 3 RAM reads -> acks are separated by RAM_WAIT+2 cycles and perf_rd_cnt=3; perf_wr_cnt and perf_err_cnt are unchanged.
